// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI command engine: FSM encoding,
// register map, CMD/STATUS bit positions, frame geometry and the CRC7 step.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_READ = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    localparam logic [1:0] ADDR_ARG    = 2'd0;
    localparam logic [1:0] ADDR_CMD    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESP   = 2'd3;

    localparam int CMD_IDX_W    = 6;
    localparam int CMD_LONG_BIT = 8;
    localparam int CMD_FAST_BIT = 9;

    localparam int STS_BUSY      = 0;
    localparam int STS_DONE      = 1;
    localparam int STS_TIMEOUT   = 2;
    localparam int STS_INIT_DONE = 3;
    localparam int STS_R1_LSB    = 8;

    localparam int FRAME_W  = 48;
    localparam int CRC_BITS = 40;
    localparam int R1_W     = 8;
    localparam int LONG_W   = 40;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one bit per enable, synchronous clear.
module sd_crc7 import sd_spi_pkg::*; (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    // CRC register: cleared per command, advanced once per frame bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= 7'h00;
        end else if (clear) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI command engine: init clocking, 48-bit command with hardware
// CRC7, R1 / 40-bit response capture with Ncr timeout, Avalon-MM registers.
module sd_spi_cmd_engine import sd_spi_pkg::*; #(
    parameter int SLOW_DIV  = 64,
    parameter int FAST_DIV  = 2,
    parameter int INIT_CLKS = 80,
    parameter int NCR_MAX   = 8,
    parameter int GAP_CLKS  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chip_select,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        sd_clk,
    output logic        sd_mosi,
    input  logic        sd_miso,
    output logic        sd_cs_n
);

    localparam int WAIT_CLKS = NCR_MAX * 8;
    localparam int CNT_MAX_A = (INIT_CLKS > WAIT_CLKS) ? INIT_CLKS : WAIT_CLKS;
    localparam int CNT_MAX   = (CNT_MAX_A > FRAME_W) ? CNT_MAX_A : FRAME_W;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int DIV_W     = $clog2(SLOW_DIV + 1);
    localparam int RX_W      = $clog2(LONG_W + 1);

    state_t             state_r, state_n;
    logic [DIV_W-1:0]   div_cnt_r, div_lim_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [RX_W-1:0]    rx_cnt_r, rx_len_s;
    logic [FRAME_W-1:0] tx_sh_r, tx_next_s;
    logic [LONG_W-1:0]  rx_sh_r;
    logic [31:0]        arg_r, resp_r, status_s, readdata_r;
    logic [7:0]         r1_r;
    logic [6:0]         crc_s;
    logic               long_r, fast_r, busy_r, done_r, timeout_r, init_done_r;
    logic               sd_clk_r, sd_mosi_r, sd_cs_n_r;
    logic               tick_s, rise_s, fall_s, cmd_wr_s, arg_wr_s, crc_en_s, bump_s;

    assign div_lim_s = fast_r ? DIV_W'(FAST_DIV - 1) : DIV_W'(SLOW_DIV - 1);
    assign tick_s    = (state_r != ST_IDLE) && (div_cnt_r == div_lim_s);
    assign rise_s    = tick_s && !sd_clk_r;
    assign fall_s    = tick_s && sd_clk_r;
    // IDLE is exactly "init done and not busy", so it gates both register writes
    assign cmd_wr_s  = chip_select && write && (address == ADDR_CMD) && (state_r == ST_IDLE);
    assign arg_wr_s  = chip_select && write && (address == ADDR_ARG) && (state_r == ST_IDLE);
    assign crc_en_s  = rise_s && (state_r == ST_SEND) && (cnt_r < CNT_W'(CRC_BITS));
    assign bump_s    = (fall_s && (state_r inside {ST_INIT, ST_SEND, ST_GAP}))
                    || (rise_s && (state_r == ST_WAIT));
    assign rx_len_s  = long_r ? RX_W'(LONG_W) : RX_W'(R1_W);
    // The CRC slots into the frame right after the 40th bit has been fed to it
    assign tx_next_s = (cnt_r == CNT_W'(CRC_BITS - 1))
                     ? {crc_s, 1'b1, tx_sh_r[FRAME_W-10:0], 1'b0}
                     : {tx_sh_r[FRAME_W-2:0], 1'b0};

    sd_crc7 u_crc7 (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cmd_wr_s),
        .en      (crc_en_s),
        .din     (sd_mosi_r),
        .crc     (crc_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_INIT;
        else          state_r <= state_n;
    end

    // FSM next-state; leaving states on a fall keeps sd_clk low at cs_n edges
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_INIT: if (fall_s && cnt_r == CNT_W'(INIT_CLKS - 1)) state_n = ST_IDLE;
                     else state_n = state_r;
            ST_IDLE: if (cmd_wr_s) state_n = ST_SEND;
                     else state_n = state_r;
            ST_SEND: if (fall_s && cnt_r == CNT_W'(FRAME_W - 1)) state_n = ST_WAIT;
                     else state_n = state_r;
            ST_WAIT: if (rise_s && !sd_miso) state_n = ST_READ;
                     else if (fall_s && cnt_r == CNT_W'(WAIT_CLKS)) state_n = ST_GAP;
                     else state_n = state_r;
            ST_READ: if (fall_s && rx_cnt_r == rx_len_s) state_n = ST_GAP;
                     else state_n = state_r;
            ST_GAP:  if (fall_s && cnt_r == CNT_W'(GAP_CLKS - 1)) state_n = ST_IDLE;
                     else state_n = state_r;
            default: state_n = ST_INIT;
        endcase
    end

    // Clock divider; the counter restarts at every sd_clk edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r <= DIV_W'(0);
            sd_clk_r  <= 1'b0;
        end else if (tick_s) begin
            div_cnt_r <= DIV_W'(0);
            sd_clk_r  <= ~sd_clk_r;
        end else if (state_r == ST_IDLE) begin
            div_cnt_r <= DIV_W'(0);
            sd_clk_r  <= 1'b0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Per-state edge counter and response shifter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= CNT_W'(0);
            rx_cnt_r <= RX_W'(0);
            rx_sh_r  <= {LONG_W{1'b0}};
        end else begin
            if (state_n != state_r) cnt_r <= CNT_W'(0);
            else if (bump_s)        cnt_r <= cnt_r + CNT_W'(1);
            if (rise_s && state_r == ST_WAIT && !sd_miso) begin
                rx_sh_r  <= {rx_sh_r[LONG_W-2:0], 1'b0};
                rx_cnt_r <= RX_W'(1);
            end else if (rise_s && state_r == ST_READ) begin
                rx_sh_r  <= {rx_sh_r[LONG_W-2:0], sd_miso};
                rx_cnt_r <= rx_cnt_r + RX_W'(1);
            end
        end
    end

    // Command shifter and pin drivers; mosi moves only on falling edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sh_r   <= {FRAME_W{1'b0}};
            sd_mosi_r <= 1'b1;
            sd_cs_n_r <= 1'b1;
        end else begin
            sd_cs_n_r <= !(state_n inside {ST_SEND, ST_WAIT, ST_READ});
            if (cmd_wr_s) begin
                tx_sh_r   <= {2'b01, writedata[CMD_IDX_W-1:0], arg_r, 8'h01};
                sd_mosi_r <= 1'b0;
            end else if (state_n != ST_SEND) begin
                sd_mosi_r <= 1'b1;
            end else if (fall_s) begin
                tx_sh_r   <= tx_next_s;
                sd_mosi_r <= tx_next_s[FRAME_W-1];
            end
        end
    end

    // Register file and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arg_r       <= 32'h0;
            resp_r      <= 32'h0;
            r1_r        <= 8'h00;
            long_r      <= 1'b0;
            fast_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            if (arg_wr_s) arg_r <= writedata;
            if (cmd_wr_s) begin
                long_r    <= writedata[CMD_LONG_BIT];
                fast_r    <= writedata[CMD_FAST_BIT];
                busy_r    <= 1'b1;
                done_r    <= 1'b0;
                timeout_r <= 1'b0;
            end
            if (state_r == ST_INIT && state_n == ST_IDLE) init_done_r <= 1'b1;
            if (state_r == ST_WAIT && state_n == ST_GAP)  timeout_r   <= 1'b1;
            if (state_r == ST_READ && state_n == ST_GAP) begin
                r1_r <= long_r ? rx_sh_r[LONG_W-1 -: 8] : rx_sh_r[7:0];
                if (long_r) resp_r <= rx_sh_r[31:0];
            end
            if (state_r == ST_GAP && state_n == ST_IDLE) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end
    end

    // STATUS word assembly
    always_comb begin
        status_s                      = 32'h0;
        status_s[STS_BUSY]            = busy_r;
        status_s[STS_DONE]            = done_r;
        status_s[STS_TIMEOUT]         = timeout_r;
        status_s[STS_INIT_DONE]       = init_done_r;
        status_s[STS_R1_LSB +: 8]     = r1_r;
    end

    // Registered read port, one cycle of latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'h0;
        end else if (chip_select && read) begin
            case (address)
                ADDR_STATUS: readdata_r <= status_s;
                ADDR_RESP:   readdata_r <= resp_r;
                default:     readdata_r <= 32'h0;
            endcase
        end
    end

    assign readdata = readdata_r;
    assign sd_clk   = sd_clk_r;
    assign sd_mosi  = sd_mosi_r;
    assign sd_cs_n  = sd_cs_n_r;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench for sd_spi_cmd_engine with a small SPI card model on the pins.
module tb_sd_spi_cmd_engine;
    import sd_spi_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chip_select;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        sd_clk, sd_mosi, sd_cs_n;
    logic        sd_miso = 1'b1;

    int          n_cmp = 0;
    int          n_err = 0;

    int          hi_rises = 0;
    int          lo_rises = 0;
    int          cs_falls = 0;
    logic [47:0] tx_frame = 48'h0;
    logic [47:0] reply = 48'h0;
    int          reply_len = 0;

    sd_spi_cmd_engine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chip_select (chip_select),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .read        (read),
        .readdata    (readdata),
        .sd_clk      (sd_clk),
        .sd_mosi     (sd_mosi),
        .sd_miso     (sd_miso),
        .sd_cs_n     (sd_cs_n)
    );

    always #5 clk = ~clk;

    // pin monitor: counts sd_clk rises by cs_n level and captures the command frame
    always @(posedge sd_clk or negedge sd_cs_n) begin
        if (sd_clk === 1'b1) begin
            if (sd_cs_n) hi_rises++;
            else begin
                if (lo_rises < 48) tx_frame = {tx_frame[46:0], sd_mosi};
                lo_rises++;
            end
        end else begin
            lo_rises = 0;
            cs_falls++;
        end
    end

    // card model: after the 48 command bits, shift out reply MSB first on falling edges
    always @(negedge sd_clk) begin
        if (!sd_cs_n && lo_rises >= 48 && (lo_rises - 48) < reply_len)
            sd_miso = reply[reply_len - 1 - (lo_rises - 48)];
        else
            sd_miso = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chip_select = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chip_select = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chip_select = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chip_select = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic wait_status(input string tag, input int bit_pos, input logic level);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            bus_read(ADDR_STATUS, s);
            n++;
        end while (s[bit_pos] !== level && n < 12000);
        check({tag, "_budget"}, 64'(n < 12000), 64'd1);
    endtask

    logic [31:0] rd;
    int          hi0, cs0, n;

    initial begin
        reset_n = 1'b0; chip_select = 1'b0; address = 2'd0;
        write = 1'b0; writedata = 32'h0; read = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_readdata", 64'(readdata), 64'h0);
        check("reset_pins", 64'({sd_clk, sd_mosi, sd_cs_n}), 64'h3);
        #2 reset_n = 1'b1;

        // 1: power-up clocking, writes dropped until init_done
        bus_read(ADDR_STATUS, rd);
        check("t1_status_in_init", 64'(rd), 64'h0);
        bus_write(ADDR_ARG, 32'h1234_5678);
        bus_write(ADDR_CMD, 32'h0000_0211);
        wait_status("t1_init", STS_INIT_DONE, 1'b1);
        check("t1_init_clocks", 64'(hi_rises), 64'd80);
        check("t1_no_txn_in_init", 64'(cs_falls), 64'd0);
        repeat (300) @(negedge clk);
        check("t1_clock_stopped", 64'(hi_rises), 64'd80);
        check("t1_sdclk_low", 64'(sd_clk), 64'd0);
        bus_read(ADDR_STATUS, rd);
        check("t1_status_idle", 64'(rd), 64'h8);

        // 2: CMD0 (fast) using the reset ARG, card answers 0x01 after one filler byte
        reply = 48'h0000_0000_FF01; reply_len = 16;
        hi0 = hi_rises;
        bus_write(ADDR_CMD, 32'h0000_0200);
        wait_status("t2_done", STS_BUSY, 1'b0);
        check("t2_frame", 64'(tx_frame), 64'h4000_0000_0095);
        bus_read(ADDR_STATUS, rd);
        check("t2_status", 64'(rd), 64'h0000_010A);
        check("t2_rises_cs_low", 64'(lo_rises), 64'd64);
        check("t2_gap_clocks", 64'(hi_rises - hi0), 64'd8);
        check("t2_idle_pins", 64'({sd_clk, sd_mosi, sd_cs_n}), 64'h3);

        // 3: CMD8 long response at slow clock
        reply = 48'hFF01_0000_01AA; reply_len = 48;
        bus_write(ADDR_ARG, 32'h0000_01AA);
        bus_write(ADDR_CMD, 32'h0000_0108);
        wait_status("t3_done", STS_BUSY, 1'b0);
        check("t3_frame", 64'(tx_frame), 64'h4800_0001_AA87);
        bus_read(ADDR_STATUS, rd);
        check("t3_status", 64'(rd), 64'h0000_010A);
        bus_read(ADDR_RESP, rd);
        check("t3_resp", 64'(rd), 64'h0000_01AA);
        check("t3_rises_cs_low", 64'(lo_rises), 64'd96);

        // 4: CMD17 with miso stuck high -> timeout after 64 wait clocks
        reply_len = 0;
        hi0 = hi_rises;
        bus_write(ADDR_CMD, 32'h0000_0211);
        wait_status("t4_done", STS_BUSY, 1'b0);
        check("t4_first_byte", 64'(tx_frame[47:40]), 64'h51);
        bus_read(ADDR_STATUS, rd);
        check("t4_status", 64'(rd), 64'h0000_010E);
        check("t4_rises_cs_low", 64'(lo_rises), 64'd112);
        check("t4_gap_clocks", 64'(hi_rises - hi0), 64'd8);

        // 5: writes while busy are dropped
        reply = 48'h0000_0000_FF01; reply_len = 16;
        bus_write(ADDR_ARG, 32'h0000_0000);
        cs0 = cs_falls;
        bus_write(ADDR_CMD, 32'h0000_0200);
        bus_read(ADDR_STATUS, rd);
        check("t5_status_busy", 64'(rd), 64'h0000_0109);
        bus_write(ADDR_CMD, 32'h0000_033F);
        bus_write(ADDR_ARG, 32'hDEAD_BEEF);
        wait_status("t5_done", STS_BUSY, 1'b0);
        check("t5_frame", 64'(tx_frame), 64'h4000_0000_0095);
        check("t5_one_txn", 64'(cs_falls - cs0), 64'd1);
        check("t5_rises_cs_low", 64'(lo_rises), 64'd64);
        bus_write(ADDR_CMD, 32'h0000_0200);
        wait_status("t5_done2", STS_BUSY, 1'b0);
        check("t5_arg_kept", 64'(tx_frame), 64'h4000_0000_0095);
        bus_read(ADDR_STATUS, rd);
        check("t5_status", 64'(rd), 64'h0000_010A);

        // 6: reset mid-SEND
        reply_len = 0;
        bus_write(ADDR_CMD, 32'h0000_0200);
        n = 0;
        while (lo_rises < 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_bit20", 64'(n < 2000), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_pins_in_reset", 64'({sd_clk, sd_mosi, sd_cs_n}), 64'h3);
        check("t6_readdata_in_reset", 64'(readdata), 64'h0);
        repeat (4) @(negedge clk);
        hi0 = hi_rises;
        #2 reset_n = 1'b1;
        wait_status("t6_init", STS_INIT_DONE, 1'b1);
        check("t6_init_clocks", 64'(hi_rises - hi0), 64'd80);
        bus_read(ADDR_STATUS, rd);
        check("t6_status_cleared", 64'(rd), 64'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
